// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the MEM stage of the core and the data memory.
// The core drives the request side; the memory answers on the response side.
interface data_mem_lsu_if;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_lsu.sv
// Data memory load/store unit for the pipelined RV32 core.
// Byte/half/word stores with lane enables, sign/zero-extending loads,
// alignment and range fault detection, a saturating fault counter and a
// response pipeline of 1 or 2 cycles (READ_LATENCY must be 1 or 2,
// ADDR_WIDTH must be 4..16).
module data_mem_lsu #(
   parameter int ADDR_WIDTH    = 10,
   parameter int READ_LATENCY  = 1,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   data_mem_lsu_if.slave            bus,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);
   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam int DEPTH = 2 ** IDX_W;

   // Contents survive reset; they start out as zero.
   logic [31:0] mem [DEPTH] = '{default: '0};

   logic [IDX_W-1:0] idx;
   logic [1:0]       lane;
   logic             fault;
   logic [3:0]       be;
   logic [31:0]      wd_lanes;
   logic [31:0]      rd_word;

   // Extract the addressed byte/half/word and extend it to 32 bits.
   // Stores and faulted requests return zero.
   function automatic logic [31:0] extract(input logic [31:0] word,
                                           input logic [1:0]  ln,
                                           input logic [1:0]  sz,
                                           input logic        uns,
                                           input logic        zero);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[8*ln +: 8];
      h = ln[1] ? word[31:16] : word[15:0];
      case (sz)
         2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return zero ? 32'h0 : r;
   endfunction

   // Increment that sticks at all-ones.
   function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] c);
      return (&c) ? c : c + ERR_CNT_WIDTH'(1);
   endfunction

   // Decode the request: word index, lane, fault flags, byte enables and lane-replicated store data.
   always_comb begin
      idx      = bus.req_addr[ADDR_WIDTH-1:2];
      lane     = bus.req_addr[1:0];
      fault    = (bus.req_addr[31:ADDR_WIDTH] != '0)
               | (bus.req_size == 2'b11)
               | ((bus.req_size == 2'b01) & bus.req_addr[0])
               | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00));
      be       = 4'b0000;
      wd_lanes = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            be       = 4'b0001 << lane;
            wd_lanes = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            be       = lane[1] ? 4'b1100 : 4'b0011;
            wd_lanes = {2{bus.req_wdata[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      rd_word  = mem[idx];
   end

   // Commit stores at the acceptance edge; faulted requests and reset block the write.
   always_ff @(posedge clk) begin
      if (!rst && bus.req_valid && bus.req_we && !fault) begin
         if (be[0]) mem[idx][7:0]   <= wd_lanes[7:0];
         if (be[1]) mem[idx][15:8]  <= wd_lanes[15:8];
         if (be[2]) mem[idx][23:16] <= wd_lanes[23:16];
         if (be[3]) mem[idx][31:24] <= wd_lanes[31:24];
      end
   end

   // Count faulted requests, saturating at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_count <= '0;
      else if (bus.req_valid && fault)
         err_count <= sat_inc(err_count);
   end

   if (READ_LATENCY == 1) begin : g_lat1
      logic        vld_p1;
      logic        err_p1;
      logic [31:0] rdata_p1;

      // Stage 1: extracted result registered at the acceptance edge.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= 32'h0;
         end else begin
            vld_p1 <= bus.req_valid;
            if (bus.req_valid) begin
               err_p1   <= fault;
               rdata_p1 <= extract(rd_word, lane, bus.req_size, bus.req_unsigned,
                                   bus.req_we | fault);
            end
         end
      end

      assign bus.rsp_valid = vld_p1;
      assign bus.rsp_err   = err_p1;
      assign bus.rsp_rdata = rdata_p1;
   end else begin : g_lat2
      logic        vld_p1;
      logic        err_p1;
      logic        zero_p1;
      logic [31:0] word_p1;
      logic [1:0]  lane_p1;
      logic [1:0]  size_p1;
      logic        uns_p1;
      logic        vld_p2;
      logic        err_p2;
      logic [31:0] rdata_p2;

      // Stage 1 control: valid, fault and zero-result flags.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
            zero_p1 <= 1'b0;
         end else begin
            vld_p1 <= bus.req_valid;
            if (bus.req_valid) begin
               err_p1  <= fault;
               zero_p1 <= bus.req_we | fault;
            end
         end
      end

      // Stage 1 data: raw word and lane selection, consumed only when vld_p1 is set.
      always_ff @(posedge clk) begin
         if (bus.req_valid) begin
            word_p1 <= rd_word;
            lane_p1 <= lane;
            size_p1 <= bus.req_size;
            uns_p1  <= bus.req_unsigned;
         end
      end

      // Stage 2: extracted and extended result.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_p2   <= 1'b0;
            err_p2   <= 1'b0;
            rdata_p2 <= 32'h0;
         end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
               err_p2   <= err_p1;
               rdata_p2 <= extract(word_p1, lane_p1, size_p1, uns_p1, zero_p1);
            end
         end
      end

      assign bus.rsp_valid = vld_p2;
      assign bus.rsp_err   = err_p2;
      assign bus.rsp_rdata = rdata_p2;
   end
endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: one instance at READ_LATENCY=1 and one at 2,
// directed request sequence, expected responses queued per instance and
// compared in order when rsp_valid appears.
module tb_data_mem_lsu;
   logic        clk;
   logic        rst;
   logic        v1, v2;
   logic        t_we, t_uns;
   logic [1:0]  t_size;
   logic [31:0] t_addr, t_wdata;
   logic [7:0]  ec1, ec2;
   int          cyc   = 0;
   int          tests = 0;
   int          fails = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];

   data_mem_lsu_if bus1();
   data_mem_lsu_if bus2();

   assign bus1.req_valid    = v1;
   assign bus1.req_we       = t_we;
   assign bus1.req_size     = t_size;
   assign bus1.req_unsigned = t_uns;
   assign bus1.req_addr     = t_addr;
   assign bus1.req_wdata    = t_wdata;
   assign bus2.req_valid    = v2;
   assign bus2.req_we       = t_we;
   assign bus2.req_size     = t_size;
   assign bus2.req_unsigned = t_uns;
   assign bus2.req_addr     = t_addr;
   assign bus2.req_wdata    = t_wdata;

   data_mem_lsu #(.ADDR_WIDTH(10), .READ_LATENCY(1), .ERR_CNT_WIDTH(8)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .err_count(ec1));
   data_mem_lsu #(.ADDR_WIDTH(10), .READ_LATENCY(2), .ERR_CNT_WIDTH(8)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2), .err_count(ec2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one request for a single edge and queue its expected response.
   task automatic req(input int d, input bit we, input logic [1:0] sz, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] er, input bit ee);
      exp_t e;
      t_we = we; t_size = sz; t_uns = uns; t_addr = addr; t_wdata = wd;
      v1 = (d == 1); v2 = (d == 2);
      e.rdata = er; e.err = ee; e.due = cyc + d;
      if (d == 1) q1.push_back(e); else q2.push_back(e);
      @(posedge clk); #1;
      v1 = 1'b0; v2 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // In-order response checking for the latency-1 instance.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus1.rsp_valid) begin
            if (q1.size() == 0) check("d1_spurious_rsp", 32'(bus1.rsp_valid), 32'd0);
            else begin
               exp_t e;
               e = q1.pop_front();
               check("d1_latency", cyc, e.due);
               check("d1_rdata", bus1.rsp_rdata, e.rdata);
               check("d1_err", 32'(bus1.rsp_err), 32'(e.err));
            end
         end else if (q1.size() > 0 && q1[0].due <= cyc) begin
            check("d1_missing_rsp", 32'(bus1.rsp_valid), 32'd1);
            q1.delete(0);
         end
      end
   end

   // In-order response checking for the latency-2 instance.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus2.rsp_valid) begin
            if (q2.size() == 0) check("d2_spurious_rsp", 32'(bus2.rsp_valid), 32'd0);
            else begin
               exp_t e;
               e = q2.pop_front();
               check("d2_latency", cyc, e.due);
               check("d2_rdata", bus2.rsp_rdata, e.rdata);
               check("d2_err", 32'(bus2.rsp_err), 32'(e.err));
            end
         end else if (q2.size() > 0 && q2[0].due <= cyc) begin
            check("d2_missing_rsp", 32'(bus2.rsp_valid), 32'd1);
            q2.delete(0);
         end
      end
   end

   initial begin
      rst = 1'b1; v1 = 1'b0; v2 = 1'b0;
      t_we = 1'b0; t_uns = 1'b0; t_size = 2'b10; t_addr = '0; t_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_d1_vld",   32'(bus1.rsp_valid), 32'd0);
      check("rst_d1_rdata", bus1.rsp_rdata, 32'h0);
      check("rst_d1_err",   32'(bus1.rsp_err), 32'd0);
      check("rst_d1_cnt",   32'(ec1), 32'd0);
      check("rst_d2_vld",   32'(bus2.rsp_valid), 32'd0);
      check("rst_d2_rdata", bus2.rsp_rdata, 32'h0);
      check("rst_d2_err",   32'(bus2.rsp_err), 32'd0);
      check("rst_d2_cnt",   32'(ec2), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Word store then word load.
      req(1, 1, 2'b10, 0, 32'h08, 32'hA5A5_1234, 32'h0, 0);
      req(1, 0, 2'b10, 0, 32'h08, 32'h0,         32'hA5A5_1234, 0);

      // Byte merge into a word, signed and unsigned byte loads.
      req(1, 1, 2'b10, 0, 32'h10, 32'h1122_3344, 32'h0, 0);
      req(1, 1, 2'b00, 0, 32'h12, 32'hABCD_EF80, 32'h0, 0);
      req(1, 0, 2'b10, 0, 32'h10, 32'h0,         32'h1180_3344, 0);
      req(1, 0, 2'b00, 0, 32'h12, 32'h0,         32'hFFFF_FF80, 0);
      req(1, 0, 2'b00, 1, 32'h12, 32'h0,         32'h0000_0080, 0);

      // Upper-half store, half and byte loads of both halves.
      req(1, 1, 2'b10, 0, 32'h20, 32'h0000_5A5A, 32'h0, 0);
      req(1, 1, 2'b01, 0, 32'h22, 32'h1234_BEEF, 32'h0, 0);
      req(1, 0, 2'b10, 0, 32'h20, 32'h0,         32'hBEEF_5A5A, 0);
      req(1, 0, 2'b01, 0, 32'h22, 32'h0,         32'hFFFF_BEEF, 0);
      req(1, 0, 2'b01, 1, 32'h22, 32'h0,         32'h0000_BEEF, 0);
      req(1, 0, 2'b01, 0, 32'h20, 32'h0,         32'h0000_5A5A, 0);
      req(1, 0, 2'b00, 0, 32'h23, 32'h0,         32'hFFFF_FFBE, 0);
      req(1, 0, 2'b00, 1, 32'h23, 32'h0,         32'h0000_00BE, 0);
      req(1, 0, 2'b10, 1, 32'h22, 32'h0,         32'h0, 1);
      check("cnt_after_first_fault", 32'(ec1), 32'd1);

      // Faults leave memory untouched.
      req(1, 1, 2'b10, 0, 32'h04, 32'h5566_7788, 32'h0, 0);
      req(1, 1, 2'b10, 0, 32'h00, 32'h0102_0304, 32'h0, 0);
      req(1, 0, 2'b01, 0, 32'h21,  32'h0,         32'h0, 1);
      req(1, 1, 2'b10, 0, 32'h06,  32'hDEAD_BEEF, 32'h0, 1);
      req(1, 1, 2'b11, 0, 32'h10,  32'hFFFF_FFFF, 32'h0, 1);
      req(1, 1, 2'b10, 0, 32'h400, 32'hCAFE_F00D, 32'h0, 1);
      check("cnt_after_5_faults", 32'(ec1), 32'd5);
      req(1, 0, 2'b10, 0, 32'h04, 32'h0, 32'h5566_7788, 0);
      req(1, 0, 2'b10, 0, 32'h00, 32'h0, 32'h0102_0304, 0);
      req(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h1180_3344, 0);

      // Saturation of the fault counter.
      for (int i = 0; i < 250; i++) req(1, 0, 2'b10, 0, 32'h401, 32'h0, 32'h0, 1);
      check("cnt_at_255", 32'(ec1), 32'd255);
      for (int i = 0; i < 50; i++) req(1, 0, 2'b10, 0, 32'h401, 32'h0, 32'h0, 1);
      check("cnt_saturated", 32'(ec1), 32'd255);
      idle(3);

      // Two-cycle latency: back-to-back store/load to the same word.
      req(2, 1, 2'b10, 0, 32'h30, 32'h1357_9BDF, 32'h0, 0);
      req(2, 0, 2'b10, 0, 32'h30, 32'h0,         32'h1357_9BDF, 0);
      req(2, 0, 2'b00, 1, 32'h31, 32'h0,         32'h0000_009B, 0);
      req(2, 0, 2'b01, 0, 32'h32, 32'h0,         32'h0000_1357, 0);
      req(2, 0, 2'b01, 0, 32'h33, 32'h0,         32'h0, 1);
      check("d2_cnt", 32'(ec2), 32'd1);
      req(2, 1, 2'b10, 0, 32'h40, 32'h0BAD_CAFE, 32'h0, 0);
      idle(4);

      // Reset while a load is in flight drops its response.
      req(2, 0, 2'b10, 0, 32'h40, 32'h0, 32'h0BAD_CAFE, 0);
      rst = 1'b1;
      q2.delete(q2.size() - 1);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("rst_drop_vld", 32'(bus2.rsp_valid), 32'd0);
      end
      check("rst_d1_cnt_clear", 32'(ec1), 32'd0);
      check("rst_d2_cnt_clear", 32'(ec2), 32'd0);
      @(posedge clk); #1;

      // Memory survives reset; behaviour matches power-up.
      req(2, 0, 2'b10, 0, 32'h40, 32'h0, 32'h0BAD_CAFE, 0);
      req(2, 0, 2'b10, 0, 32'h30, 32'h0, 32'h1357_9BDF, 0);
      req(1, 0, 2'b10, 0, 32'h08, 32'h0, 32'hA5A5_1234, 0);
      req(1, 0, 2'b01, 0, 32'h09, 32'h0, 32'h0, 1);
      check("post_rst_cnt", 32'(ec1), 32'd1);
      idle(5);
      check("q1_drained", q1.size(), 32'd0);
      check("q2_drained", q2.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
